kalman_sequencer: RTL and testbench
===================================

KALMAN_SEQUENCER -- requirements
Module: kalman_sequencer

Interface
REQ-001 Parameter: FILT_TIMEOUT, default 1023, maximum clk cycles allowed in COMPUTE.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 n_rst  in  1  reset, asynchronous and active-low.
REQ-004 cfg_done  in  1  level; SPI configuration complete.
REQ-005 acc_addr, gyro_addr, mag_addr  in  7 each  configured sensor addresses, stable once cfg_done=1.
REQ-006 rx_valid  in  1  one-cycle pulse; I2C receiver finished a 6-byte packet.
REQ-007 rx_addr  in  7  address of that packet, valid with rx_valid.
REQ-008 rx_data  in  48  payload of that packet, valid with rx_valid.
REQ-009 frame_acc, frame_gyro, frame_mag  out  48 each  registered sensor frames to the filter.
REQ-010 filt_start  out  1  one-cycle pulse launching the filter.
REQ-011 filt_done  in  1  one-cycle pulse; filter results valid.
REQ-012 filt_roll, filt_pitch, filt_yaw  in  16 each  filter results, valid with filt_done.
REQ-013 spi_word  out  16  word presented to the SPI transmitter.
REQ-014 data_ready  out  1  spi_word valid for readout.
REQ-015 spi_word_ack  in  1  one-cycle pulse; SPI master has shifted out all 16 bits.
REQ-016 frame_count  out  8  number of filt_start pulses issued, mod 256.
REQ-017 err_overrun, err_timeout  out  1 each  sticky error flags.

Function
REQ-018 States: IDLE, COLLECT, START, COMPUTE, OUT_ROLL, OUT_PITCH, OUT_YAW.
REQ-019 IDLE -> COLLECT on the first cycle with cfg_done=1; cfg_done is ignored in all other states.
REQ-020 In COLLECT, an rx_valid whose rx_addr matches acc_addr, gyro_addr or mag_addr loads rx_data into the matching frame register and sets that sensor's have-flag.
REQ-021 A repeated match for a sensor that already has its flag set overwrites the frame, with the latest packet winning; it is not an error.
REQ-022 An rx_addr matching no configured address is dropped silently.
REQ-023 When two or more configured addresses are equal, priority is acc, then gyro, then mag.
REQ-024 The cycle after all three have-flags are set: state goes to START, filt_start=1 for exactly one cycle, frame_count increments (255 wraps to 0), all flags clear, then state goes to COMPUTE.
REQ-025 Frame registers hold steady from START until the state returns to COLLECT.
REQ-026 rx_valid in any state other than IDLE or COLLECT sets err_overrun; the packet is dropped.
REQ-027 rx_valid in IDLE is ignored with no error.
REQ-028 COMPUTE: a cycle counter starts at 0 on entry.
REQ-029 COMPUTE, filt_done=1: latch roll, pitch and yaw into internal registers and go to OUT_ROLL.
REQ-030 COMPUTE timeout: if the counter reaches FILT_TIMEOUT without filt_done, set err_timeout and go to COLLECT with no readout.
REQ-031 filt_done outside COMPUTE is ignored.
REQ-032 OUT_x: spi_word equals the latched value (roll, pitch or yaw respectively).
REQ-033 OUT_x: data_ready=1 except for one gap cycle immediately after entering OUT_PITCH or OUT_YAW, where data_ready=0.
REQ-034 spi_word_ack while data_ready=1 advances the state: ROLL -> PITCH -> YAW -> COLLECT.
REQ-035 data_ready falls the cycle after an ack.
REQ-036 spi_word_ack while data_ready=0, or in any non-OUT state, is ignored.
REQ-037 spi_word holds its last value outside the OUT states.
REQ-038 All outputs are registered.

Reset
REQ-039 n_rst=0 forces, immediately and asynchronously: state IDLE; all flags clear; frame registers, latched results and spi_word 0; filt_start, data_ready, err_overrun, err_timeout 0; frame_count 0; timeout counter 0.
REQ-040 Reset mid-frame or mid-readout discards all progress; after release the block waits for cfg_done again.
REQ-041 Sticky errors clear only on reset.

Verification
REQ-042 Addresses 0x78/0x79/0x7A, cfg_done=1; rx packets 0x78, 0x79, 0x7A -> single filt_start pulse the cycle after the third packet, frame_count=1, frames match the payloads.
REQ-043 filt_done with roll/pitch/yaw = 0x0011/0x0022/0x0033, three acks each spaced 160 cycles apart -> spi_word sequence 0x0011, 0x0022, 0x0033; data_ready low for exactly 1 cycle between words; state returns to COLLECT after the third ack.
REQ-044 Packets 0x78 (data A), 0x78 (data B), 0x79, 0x7A, plus a packet to 0x55 -> frame_acc=B; 0x55 has no effect; no error flag set.
REQ-045 FILT_TIMEOUT=8 and filt_done withheld -> err_timeout=1 after 8 cycles in COMPUTE, data_ready never asserted, next three packets start a new frame.
REQ-046 rx_valid during OUT_PITCH -> err_overrun=1 and frame registers unchanged.
REQ-047 n_rst pulsed low during OUT_PITCH -> all outputs 0 at once; 256 completed frames leave frame_count=0.

Source files
------------

// File: rtl/kalman_sequencer.sv
// Sensor-frame sequencer: gathers one I2C packet per configured sensor, launches the
// attitude filter, then presents roll, pitch and yaw to the SPI transmitter one word at a time.
module kalman_sequencer #(
    parameter int unsigned FILT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cfg_done,
    input  logic [6:0]  acc_addr,
    input  logic [6:0]  gyro_addr,
    input  logic [6:0]  mag_addr,
    input  logic        rx_valid,
    input  logic [6:0]  rx_addr,
    input  logic [47:0] rx_data,
    output logic [47:0] frame_acc,
    output logic [47:0] frame_gyro,
    output logic [47:0] frame_mag,
    output logic        filt_start,
    input  logic        filt_done,
    input  logic [15:0] filt_roll,
    input  logic [15:0] filt_pitch,
    input  logic [15:0] filt_yaw,
    output logic [15:0] spi_word,
    output logic        data_ready,
    input  logic        spi_word_ack,
    output logic [7:0]  frame_count,
    output logic        err_overrun,
    output logic        err_timeout
);

    localparam int unsigned TW = $clog2(FILT_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(FILT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        COMPUTE,
        OUT_ROLL,
        OUT_PITCH,
        OUT_YAW
    } state_t;

    state_t        state, next_state;
    logic          have_acc, have_gyro, have_mag;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [15:0]   roll_q, pitch_q, yaw_q;
    logic [15:0]   roll_d, pitch_d, yaw_d;
    logic [15:0]   spi_word_d;
    logic          data_ready_d;
    logic          ld_acc, ld_gyro, ld_mag;
    logic          start_go;
    logic          ld_results;
    logic          timeout_hit;
    logic          overrun;
    logic          next_is_out;

    // NOTE: every signal gets a default before the case statement, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        tcnt_d      = tcnt;
        ld_acc      = 1'b0;
        ld_gyro     = 1'b0;
        ld_mag      = 1'b0;
        start_go    = 1'b0;
        ld_results  = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_done) next_state = COLLECT;
            end
            COLLECT: begin
                // Equal addresses resolve acc first, then gyro, then mag.
                if (rx_valid) begin
                    if (rx_addr == acc_addr)       ld_acc  = 1'b1;
                    else if (rx_addr == gyro_addr) ld_gyro = 1'b1;
                    else if (rx_addr == mag_addr)  ld_mag  = 1'b1;
                end
                if (have_acc && have_gyro && have_mag) begin
                    start_go   = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                tcnt_d     = '0;
                next_state = COMPUTE;
            end
            COMPUTE: begin
                if (filt_done) begin
                    ld_results = 1'b1;
                    next_state = OUT_ROLL;
                end else if (tcnt == TCNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = COLLECT;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            OUT_ROLL: begin
                if (spi_word_ack && data_ready) next_state = OUT_PITCH;
            end
            OUT_PITCH: begin
                if (spi_word_ack && data_ready) next_state = OUT_YAW;
            end
            OUT_YAW: begin
                if (spi_word_ack && data_ready) next_state = COLLECT;
            end
            default: next_state = IDLE;
        endcase
    end

    assign overrun = rx_valid && (state != IDLE) && (state != COLLECT);

    // Next values of the result latches feed the spi_word mux so the word is
    // already correct on the first cycle of each OUT state.
    assign roll_d  = ld_results ? filt_roll  : roll_q;
    assign pitch_d = ld_results ? filt_pitch : pitch_q;
    assign yaw_d   = ld_results ? filt_yaw   : yaw_q;

    assign next_is_out = (next_state == OUT_ROLL) || (next_state == OUT_PITCH) ||
                         (next_state == OUT_YAW);

    // Roll is ready on entry; pitch and yaw get one idle cycle after each ack.
    assign data_ready_d = next_is_out && ((next_state == state) || (state == COMPUTE));

    always_comb begin
        spi_word_d = spi_word;
        case (next_state)
            OUT_ROLL:  spi_word_d = roll_d;
            OUT_PITCH: spi_word_d = pitch_d;
            OUT_YAW:   spi_word_d = yaw_d;
            default:   spi_word_d = spi_word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            have_acc    <= 1'b0;
            have_gyro   <= 1'b0;
            have_mag    <= 1'b0;
            frame_acc   <= '0;
            frame_gyro  <= '0;
            frame_mag   <= '0;
            filt_start  <= 1'b0;
            frame_count <= '0;
            tcnt        <= '0;
            roll_q      <= '0;
            pitch_q     <= '0;
            yaw_q       <= '0;
            spi_word    <= '0;
            data_ready  <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (ld_acc)  frame_acc  <= rx_data;
            if (ld_gyro) frame_gyro <= rx_data;
            if (ld_mag)  frame_mag  <= rx_data;

            if (start_go) begin
                have_acc  <= 1'b0;
                have_gyro <= 1'b0;
                have_mag  <= 1'b0;
            end else begin
                if (ld_acc)  have_acc  <= 1'b1;
                if (ld_gyro) have_gyro <= 1'b1;
                if (ld_mag)  have_mag  <= 1'b1;
            end

            filt_start <= start_go;
            if (start_go) frame_count <= frame_count + 8'd1;

            tcnt       <= tcnt_d;
            roll_q     <= roll_d;
            pitch_q    <= pitch_d;
            yaw_q      <= yaw_d;
            spi_word   <= spi_word_d;
            data_ready <= data_ready_d;

            if (overrun)     err_overrun <= 1'b1;
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kalman_sequencer.sv
// Directed self-checking bench for kalman_sequencer: frame collection, filter launch,
// readout handshake, timeout, overrun, asynchronous reset and frame_count wrap.
module tb_kalman_sequencer;

    logic        clk;
    logic        n_rst;
    logic        cfg_done;
    logic [6:0]  acc_addr, gyro_addr, mag_addr;
    logic        rx_valid;
    logic [6:0]  rx_addr;
    logic [47:0] rx_data;
    logic [47:0] frame_acc, frame_gyro, frame_mag;
    logic        filt_start;
    logic        filt_done;
    logic [15:0] filt_roll, filt_pitch, filt_yaw;
    logic [15:0] spi_word;
    logic        data_ready;
    logic        spi_word_ack;
    logic [7:0]  frame_count;
    logic        err_overrun, err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    kalman_sequencer #(.FILT_TIMEOUT(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cfg_done     (cfg_done),
        .acc_addr     (acc_addr),
        .gyro_addr    (gyro_addr),
        .mag_addr     (mag_addr),
        .rx_valid     (rx_valid),
        .rx_addr      (rx_addr),
        .rx_data      (rx_data),
        .frame_acc    (frame_acc),
        .frame_gyro   (frame_gyro),
        .frame_mag    (frame_mag),
        .filt_start   (filt_start),
        .filt_done    (filt_done),
        .filt_roll    (filt_roll),
        .filt_pitch   (filt_pitch),
        .filt_yaw     (filt_yaw),
        .spi_word     (spi_word),
        .data_ready   (data_ready),
        .spi_word_ack (spi_word_ack),
        .frame_count  (frame_count),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] a, input logic [47:0] d);
        rx_valid = 1'b1;
        rx_addr  = a;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y);
        filt_done  = 1'b1;
        filt_roll  = r;
        filt_pitch = p;
        filt_yaw   = y;
        tick();
        filt_done  = 1'b0;
    endtask

    task automatic ack();
        spi_word_ack = 1'b1;
        tick();
        spi_word_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},  frame_acc,  48'h0);
        check({tag, "_gyro"}, frame_gyro, 48'h0);
        check({tag, "_mag"},  frame_mag,  48'h0);
        check({tag, "_ctl"},  {filt_start, data_ready, err_overrun, err_timeout}, 4'h0);
        check({tag, "_spi"},  spi_word,   16'h0);
        check({tag, "_cnt"},  frame_count, 8'h0);
    endtask

    // One complete frame through filter and readout; ends back in COLLECT.
    task automatic do_frame(input int idx);
        send(7'h78, 48'(idx));
        send(7'h79, 48'(idx + 1));
        send(7'h7A, 48'(idx + 2));
        tick();
        check("loop_start", filt_start, 1'b1);
        tick();
        pulse_done(16'(idx), 16'h0, 16'h0);
        ack();
        tick();
        ack();
        tick();
        ack();
    endtask

    initial begin
        n_rst = 1'b0;
        cfg_done = 1'b0;
        acc_addr = 7'h78;
        gyro_addr = 7'h79;
        mag_addr = 7'h7A;
        rx_valid = 1'b0;
        rx_addr = '0;
        rx_data = '0;
        filt_done = 1'b0;
        filt_roll = '0;
        filt_pitch = '0;
        filt_yaw = '0;
        spi_word_ack = 1'b0;

        #12;
        check_all_zero("reset");
        n_rst = 1'b1;
        tick();

        // Packet while idle: ignored, no error.
        send(7'h78, 48'h1111_2222_3333);
        check("idle_rx_err", err_overrun, 1'b0);
        check("idle_rx_acc", frame_acc, 48'h0);

        cfg_done = 1'b1;
        tick();

        // Basic frame.
        send(7'h78, 48'hA1A1_A1A1_A1A1);
        send(7'h79, 48'hB2B2_B2B2_B2B2);
        send(7'h7A, 48'hC3C3_C3C3_C3C3);
        check("start_early", filt_start, 1'b0);
        tick();
        check("start_pulse", filt_start, 1'b1);
        check("count_1", frame_count, 8'd1);
        check("frame_acc_1", frame_acc, 48'hA1A1_A1A1_A1A1);
        check("frame_gyro_1", frame_gyro, 48'hB2B2_B2B2_B2B2);
        check("frame_mag_1", frame_mag, 48'hC3C3_C3C3_C3C3);
        tick();
        check("start_end", filt_start, 1'b0);

        // Readout with acks 160 cycles apart.
        pulse_done(16'h0011, 16'h0022, 16'h0033);
        check("roll_ready", data_ready, 1'b1);
        check("roll_word", spi_word, 16'h0011);
        for (int i = 0; i < 159; i++) begin
            tick();
            check("roll_hold", data_ready, 1'b1);
        end
        ack();
        check("pitch_gap", data_ready, 1'b0);
        check("pitch_word", spi_word, 16'h0022);
        for (int i = 0; i < 159; i++) begin
            tick();
            check("pitch_hold", data_ready, 1'b1);
        end
        ack();
        check("yaw_gap", data_ready, 1'b0);
        check("yaw_word", spi_word, 16'h0033);
        // Ack during the gap and a stray filt_done must both be ignored.
        spi_word_ack = 1'b1;
        filt_done = 1'b1;
        filt_yaw = 16'h7777;
        tick();
        spi_word_ack = 1'b0;
        filt_done = 1'b0;
        check("gap_ack_ign", data_ready, 1'b1);
        check("stray_done", spi_word, 16'h0033);
        for (int i = 0; i < 158; i++) tick();
        ack();
        check("readout_end", data_ready, 1'b0);
        check("spi_hold", spi_word, 16'h0033);

        // Overwrite and unknown address.
        send(7'h78, 48'h0000_0000_00AA);
        send(7'h78, 48'h0000_0000_00BB);
        send(7'h55, 48'hFFFF_FFFF_FFFF);
        send(7'h79, 48'h0000_0000_0022);
        send(7'h7A, 48'h0000_0000_0033);
        tick();
        check("start_2", filt_start, 1'b1);
        check("count_2", frame_count, 8'd2);
        check("latest_wins", frame_acc, 48'h0000_0000_00BB);
        check("gyro_2", frame_gyro, 48'h0000_0000_0022);
        check("mag_2", frame_mag, 48'h0000_0000_0033);
        check("no_err", {err_overrun, err_timeout}, 2'b00);

        // Timeout: filt_done withheld.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_no_ready", data_ready, 1'b0);
        end
        check("to_not_yet", err_timeout, 1'b0);
        tick();
        check("to_set", err_timeout, 1'b1);
        check("to_no_ready2", data_ready, 1'b0);
        send(7'h78, 48'h3333_0000_0001);
        send(7'h79, 48'h3333_0000_0002);
        send(7'h7A, 48'h3333_0000_0003);
        tick();
        check("start_3", filt_start, 1'b1);
        check("count_3", frame_count, 8'd3);
        check("acc_3", frame_acc, 48'h3333_0000_0001);

        // Overrun during OUT_PITCH.
        tick();
        pulse_done(16'h0A0A, 16'h0B0B, 16'h0C0C);
        check("roll_word_4", spi_word, 16'h0A0A);
        ack();
        check("pitch_word_4", spi_word, 16'h0B0B);
        send(7'h78, 48'hDEAD_DEAD_DEAD);
        check("overrun", err_overrun, 1'b1);
        check("overrun_acc", frame_acc, 48'h3333_0000_0001);
        check("to_sticky", err_timeout, 1'b1);

        // Asynchronous reset mid-readout.
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        cfg_done = 1'b0;
        #3;
        n_rst = 1'b1;
        send(7'h78, 48'h1);
        send(7'h79, 48'h2);
        send(7'h7A, 48'h3);
        tick();
        check("wait_cfg_start", filt_start, 1'b0);
        tick();
        check("wait_cfg_cnt", frame_count, 8'd0);
        check("wait_cfg_acc", frame_acc, 48'h0);
        check("wait_cfg_err", err_overrun, 1'b0);

        // frame_count wrap after 256 frames.
        cfg_done = 1'b1;
        tick();
        for (int f = 0; f < 256; f++) begin
            do_frame(f);
            if (f == 254) check("count_255", frame_count, 8'd255);
        end
        check("count_wrap", frame_count, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
